// File: rtl/serdesphy_link_pkg.sv
// Shared state encodings and default timing constants for the SerDes link bring-up sequencer.
package serdesphy_link_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPllRst  = 3'd1,
    StPllWait = 3'd2,
    StCdrRst  = 3'd3,
    StCdrWait = 3'd4,
    StAlign   = 3'd5,
    StLinkUp  = 3'd6,
    StFault   = 3'd7
  } seq_state_e;

  localparam int unsigned DefTmrW         = 16;
  localparam int unsigned DefPllTimeout   = 24000;
  localparam int unsigned DefCdrTimeout   = 12000;
  localparam int unsigned DefAlignTimeout = 4800;
  localparam int unsigned DefRstPulse     = 8;
  localparam int unsigned DefMaxRetry     = 3;

endpackage

// File: rtl/serdesphy_link_timer.sv
// Clearable saturating up-counter with a compare-equal flag; shared by pulse and timeout phases.
module serdesphy_link_timer #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] cmp_i,
  output logic             eq_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign eq_o = (count_q == cmp_i);

endmodule

// File: rtl/serdesphy_link_seq.sv
// SerDes link bring-up sequencer: PLL, CDR and alignment phases with bounded retries.
// Optional link-drop statistics counter enabled by defining SERDESPHY_LINK_STATS_EN.
module serdesphy_link_seq
  import serdesphy_link_pkg::*;
#(
  parameter int unsigned TMR_W         = DefTmrW,
  parameter int unsigned PLL_TIMEOUT   = DefPllTimeout,
  parameter int unsigned CDR_TIMEOUT   = DefCdrTimeout,
  parameter int unsigned ALIGN_TIMEOUT = DefAlignTimeout,
  parameter int unsigned RST_PULSE     = DefRstPulse,
  parameter int unsigned MAX_RETRY     = DefMaxRetry
) (
  input  logic       clk_ref_24m,
  input  logic       rst,
  input  logic       bring_up_en,
  input  logic       pll_lock,
  input  logic       cdr_lock,
  input  logic       rx_aligned,
  output logic       pll_rst_o,
  output logic       cdr_rst_o,
  output logic       align_rst_o,
  output logic       tx_en_o,
  output logic       rx_en_o,
  output logic       link_up,
  output logic       fault,
  output logic [2:0] seq_state,
  output logic [1:0] retry_cnt,
  output logic [7:0] link_drop_cnt
);

  seq_state_e state_q, state_d, retry_tgt;
  logic [1:0] retry_q, retry_d;
  logic       take_retry;
  logic       tmr_eq, tmr_en, tmr_clr;
  logic [TMR_W-1:0] tmr_cmp;

  always_comb begin
    unique case (state_q)
      StPllRst, StCdrRst: tmr_cmp = TMR_W'(RST_PULSE - 1);
      StPllWait:          tmr_cmp = TMR_W'(PLL_TIMEOUT - 1);
      StCdrWait:          tmr_cmp = TMR_W'(CDR_TIMEOUT - 1);
      StAlign:            tmr_cmp = TMR_W'(ALIGN_TIMEOUT - 1);
      default:            tmr_cmp = '0;
    endcase
  end

  assign tmr_en  = state_q inside {StPllRst, StPllWait, StCdrRst, StCdrWait, StAlign};
  assign tmr_clr = (state_d != state_q);

  serdesphy_link_timer #(
    .Width(TMR_W)
  ) u_timer (
    .clk_i (clk_ref_24m),
    .rst_i (rst),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .cmp_i (tmr_cmp),
    .eq_o  (tmr_eq)
  );

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    take_retry = 1'b0;
    retry_tgt  = StIdle;
    if (!bring_up_en) begin
      state_d = StIdle;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StIdle:   state_d = StPllRst;
        StPllRst: if (tmr_eq) state_d = StPllWait;
        StPllWait: begin
          if (pll_lock) begin
            state_d = StCdrRst;
          end else if (tmr_eq) begin
            take_retry = 1'b1;
            retry_tgt  = StPllRst;
          end
        end
        StCdrRst: if (tmr_eq) state_d = StCdrWait;
        StCdrWait: begin
          if (!pll_lock) begin
            take_retry = 1'b1;
            retry_tgt  = StPllRst;
          end else if (cdr_lock) begin
            state_d = StAlign;
          end else if (tmr_eq) begin
            take_retry = 1'b1;
            retry_tgt  = StCdrRst;
          end
        end
        StAlign: begin
          if (!pll_lock) begin
            take_retry = 1'b1;
            retry_tgt  = StPllRst;
          end else if (rx_aligned) begin
            state_d = StLinkUp;
          end else if (tmr_eq) begin
            take_retry = 1'b1;
            retry_tgt  = StCdrRst;
          end
        end
        StLinkUp: begin
          if (!pll_lock) begin
            take_retry = 1'b1;
            retry_tgt  = StPllRst;
          end else if (!cdr_lock || !rx_aligned) begin
            take_retry = 1'b1;
            retry_tgt  = StCdrRst;
          end
        end
        StFault: state_d = StFault;
      endcase
    end
    if (take_retry) begin
      if (retry_q == 2'(MAX_RETRY)) begin
        state_d = StFault;
      end else begin
        state_d = retry_tgt;
        retry_d = retry_q + 2'd1;
      end
    end
    if ((state_d == StLinkUp) && (state_q != StLinkUp)) begin
      retry_d = '0;
    end
  end

  // Outputs are decoded from the next state and registered, so they track state_q exactly.
  always_ff @(posedge clk_ref_24m) begin
    if (rst) begin
      state_q     <= StIdle;
      retry_q     <= '0;
      pll_rst_o   <= 1'b0;
      cdr_rst_o   <= 1'b0;
      align_rst_o <= 1'b0;
      tx_en_o     <= 1'b0;
      rx_en_o     <= 1'b0;
      link_up     <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      pll_rst_o   <= (state_d == StPllRst);
      cdr_rst_o   <= (state_d == StCdrRst);
      align_rst_o <= (state_d == StAlign) && (state_q != StAlign);
      tx_en_o     <= state_d inside {StCdrRst, StCdrWait, StAlign, StLinkUp};
      rx_en_o     <= state_d inside {StAlign, StLinkUp};
      link_up     <= (state_d == StLinkUp);
      fault       <= (state_d == StFault);
    end
  end

  assign seq_state = state_q;
  assign retry_cnt = retry_q;

`ifdef SERDESPHY_LINK_STATS_EN
  logic [7:0] drop_cnt_q;
  logic       link_drop;

  // With bring_up_en high, any exit from LINK_UP is a loss of lock or alignment.
  assign link_drop = bring_up_en && (state_q == StLinkUp) && (state_d != StLinkUp);

  always_ff @(posedge clk_ref_24m) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (link_drop && (drop_cnt_q != 8'hff)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign link_drop_cnt = drop_cnt_q;
`else
  assign link_drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_serdesphy_link_seq.sv
// Self-checking bench for serdesphy_link_seq: directed scenarios plus randomized lock activity
// compared cycle by cycle against a behavioural model of the bring-up rules.
module tb_serdesphy_link_seq;

  localparam int unsigned TmrW     = 16;
  localparam int unsigned PllTo    = 100;
  localparam int unsigned CdrTo    = 60;
  localparam int unsigned AlignTo  = 40;
  localparam int unsigned RstPulse = 8;
  localparam int unsigned MaxRetry = 3;

  logic       clk_ref_24m = 1'b0;
  logic       rst, bring_up_en, pll_lock, cdr_lock, rx_aligned;
  logic       pll_rst_o, cdr_rst_o, align_rst_o, tx_en_o, rx_en_o, link_up, fault;
  logic [2:0] seq_state;
  logic [1:0] retry_cnt;
  logic [7:0] link_drop_cnt;

  always #5 clk_ref_24m = ~clk_ref_24m;

  serdesphy_link_seq #(
    .TMR_W        (TmrW),
    .PLL_TIMEOUT  (PllTo),
    .CDR_TIMEOUT  (CdrTo),
    .ALIGN_TIMEOUT(AlignTo),
    .RST_PULSE    (RstPulse),
    .MAX_RETRY    (MaxRetry)
  ) dut (
    .clk_ref_24m  (clk_ref_24m),
    .rst          (rst),
    .bring_up_en  (bring_up_en),
    .pll_lock     (pll_lock),
    .cdr_lock     (cdr_lock),
    .rx_aligned   (rx_aligned),
    .pll_rst_o    (pll_rst_o),
    .cdr_rst_o    (cdr_rst_o),
    .align_rst_o  (align_rst_o),
    .tx_en_o      (tx_en_o),
    .rx_en_o      (rx_en_o),
    .link_up      (link_up),
    .fault        (fault),
    .seq_state    (seq_state),
    .retry_cnt    (retry_cnt),
    .link_drop_cnt(link_drop_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase number, cycles spent in the phase, retries used, link drops, entry pulse.
  int m_st, m_el, m_retry, m_drops;
  bit m_align;

  int n_pll_hi, n_pll_rise, n_cdr_hi, n_align;
  bit prev_pll;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int  ns, tgt;
    bit  retry, drop;
    ns = m_st; tgt = 0; retry = 0; drop = 0; m_align = 0;
    if (rst) begin
      m_st = 0; m_el = 0; m_retry = 0; m_drops = 0;
      return;
    end
    if (!bring_up_en) begin
      ns = 0;
      m_retry = 0;
    end else begin
      case (m_st)
        0: ns = 1;
        1: if (m_el == RstPulse - 1) ns = 2;
        2: if (pll_lock) ns = 3; else if (m_el == PllTo - 1) begin retry = 1; tgt = 1; end
        3: if (m_el == RstPulse - 1) ns = 4;
        4: begin
          if (!pll_lock) begin retry = 1; tgt = 1; end
          else if (cdr_lock) ns = 5;
          else if (m_el == CdrTo - 1) begin retry = 1; tgt = 3; end
        end
        5: begin
          if (!pll_lock) begin retry = 1; tgt = 1; end
          else if (rx_aligned) ns = 6;
          else if (m_el == AlignTo - 1) begin retry = 1; tgt = 3; end
        end
        6: begin
          if (!pll_lock) begin retry = 1; tgt = 1; drop = 1; end
          else if (!cdr_lock || !rx_aligned) begin retry = 1; tgt = 3; drop = 1; end
        end
        default: ns = 7;
      endcase
    end
    if (retry) begin
      if (m_retry == MaxRetry) ns = 7;
      else begin ns = tgt; m_retry++; end
    end
    if (ns == 6 && m_st != 6) m_retry = 0;
    if (drop && m_drops < 255) m_drops++;
    m_align = (ns == 5 && m_st != 5);
    m_el = (ns != m_st) ? 0 : ((m_el < 65535) ? m_el + 1 : m_el);
    m_st = ns;
  endtask

  task automatic compare_all();
    check_eq("seq_state", seq_state, m_st);
    check_eq("pll_rst_o", pll_rst_o, int'(m_st == 1));
    check_eq("cdr_rst_o", cdr_rst_o, int'(m_st == 3));
    check_eq("align_rst_o", align_rst_o, int'(m_align));
    check_eq("tx_en_o", tx_en_o, int'(m_st >= 3 && m_st <= 6));
    check_eq("rx_en_o", rx_en_o, int'(m_st == 5 || m_st == 6));
    check_eq("link_up", link_up, int'(m_st == 6));
    check_eq("fault", fault, int'(m_st == 7));
    check_eq("retry_cnt", retry_cnt, m_retry);
`ifdef SERDESPHY_LINK_STATS_EN
    check_eq("link_drop_cnt", link_drop_cnt, m_drops);
`else
    check_eq("link_drop_cnt", link_drop_cnt, 0);
`endif
  endtask

  task automatic tick();
    @(posedge clk_ref_24m);
    model_step();
    #1;
    compare_all();
    if (pll_rst_o) n_pll_hi++;
    if (pll_rst_o && !prev_pll) n_pll_rise++;
    prev_pll = pll_rst_o;
    if (cdr_rst_o) n_cdr_hi++;
    if (align_rst_o) n_align++;
  endtask

  task automatic clear_counts();
    n_pll_hi = 0; n_pll_rise = 0; n_cdr_hi = 0; n_align = 0;
  endtask

  task automatic do_reset();
    rst = 1; bring_up_en = 0; pll_lock = 0; cdr_lock = 0; rx_aligned = 0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic run_until(input int st, input int budget, input string tag);
    int n = 0;
    while (m_st != st && n < budget) begin tick(); n++; end
    check_eq(tag, seq_state, st);
  endtask

  initial begin
    prev_pll = 0;
    clear_counts();
    // Reset state
    do_reset();
    check_eq("rst_state", seq_state, 0);
    check_eq("rst_retry", retry_cnt, 0);

    // Nominal bring-up
    clear_counts();
    bring_up_en = 1;
    repeat (20) tick();
    pll_lock = 1;
    repeat (30) tick();
    cdr_lock = 1;
    repeat (10) tick();
    rx_aligned = 1;
    tick();
    check_eq("nom_link_up", link_up, 1);
    check_eq("nom_pll_rst_cycles", n_pll_hi, 8);
    check_eq("nom_cdr_rst_cycles", n_cdr_hi, 8);
    check_eq("nom_align_pulses", n_align, 1);
    check_eq("nom_retry", retry_cnt, 0);

    // One-cycle alignment drop at LINK_UP
    rx_aligned = 0;
    tick();
    rx_aligned = 1;
    check_eq("drop_state", seq_state, 3);
    check_eq("drop_cdr_rst", cdr_rst_o, 1);
    check_eq("drop_retry", retry_cnt, 1);
    check_eq("drop_link_up", link_up, 0);
`ifdef SERDESPHY_LINK_STATS_EN
    check_eq("drop_stats", link_drop_cnt, 1);
`endif

    // PLL never locks: initial attempt plus three retries, then FAULT
    do_reset();
    clear_counts();
    bring_up_en = 1;
    run_until(7, 1000, "pto_reach_fault");
    check_eq("pto_fault", fault, 1);
    check_eq("pto_pll_pulses", n_pll_rise, 4);
    check_eq("pto_pll_rst_cycles", n_pll_hi, 32);
    repeat (5) tick();
    check_eq("pto_fault_held", seq_state, 7);
    bring_up_en = 0;
    tick();
    check_eq("pto_idle", seq_state, 0);
    check_eq("pto_fault_clear", fault, 0);

    // PLL loss during ALIGN
    do_reset();
    bring_up_en = 1; pll_lock = 1; cdr_lock = 1;
    run_until(5, 100, "ploss_reach_align");
    repeat (3) tick();
    pll_lock = 0;
    tick();
    check_eq("ploss_state", seq_state, 1);
    check_eq("ploss_retry", retry_cnt, 1);
    check_eq("ploss_tx_en", tx_en_o, 0);
    check_eq("ploss_rx_en", rx_en_o, 0);

    // cdr_lock arrives on the last timeout cycle: lock wins
    do_reset();
    bring_up_en = 1; pll_lock = 1;
    run_until(4, 100, "sim_reach_cdr_wait");
    for (int i = 0; i < 200 && m_el != CdrTo - 1; i++) tick();
    cdr_lock = 1;
    tick();
    check_eq("sim_state", seq_state, 5);
    check_eq("sim_retry", retry_cnt, 0);

    // Reset asserted mid CDR_WAIT
    do_reset();
    bring_up_en = 1; pll_lock = 1;
    run_until(4, 100, "rstmid_reach_cdr_wait");
    repeat (5) tick();
    rst = 1;
    tick();
    check_eq("rstmid_state", seq_state, 0);
    check_eq("rstmid_tx_en", tx_en_o, 0);
    check_eq("rstmid_cdr_rst", cdr_rst_o, 0);
    rst = 0;

    // Randomized lock activity
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      bring_up_en = ($urandom_range(0, 199) != 0);
      if (!pll_lock) pll_lock = ($urandom_range(0, 99) < 8);
      else pll_lock = ($urandom_range(0, 999) >= 4);
      if (!cdr_lock) cdr_lock = ($urandom_range(0, 99) < 10);
      else cdr_lock = ($urandom_range(0, 999) >= 10);
      if (!rx_aligned) rx_aligned = ($urandom_range(0, 99) < 10);
      else rx_aligned = ($urandom_range(0, 999) >= 10);
      tick();
    end

    // Link-drop statistics saturation
    do_reset();
    bring_up_en = 1; pll_lock = 1; cdr_lock = 1; rx_aligned = 1;
    run_until(6, 200, "stats_first_link");
    for (int i = 0; i < 260; i++) begin
      rx_aligned = 0;
      tick();
      rx_aligned = 1;
      run_until(6, 50, "stats_relink");
    end
`ifdef SERDESPHY_LINK_STATS_EN
    check_eq("stats_saturate", link_drop_cnt, 255);
`else
    check_eq("stats_tied_zero", link_drop_cnt, 0);
`endif
    bring_up_en = 0;
    tick();
    check_eq("stats_en_low_idle", seq_state, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
